lane_shifter_pipe: RTL and testbench

- Pipelined, parametrised lane-granular shifter. Successor to the combinational 96-bit left-shift-with-fill block.
- Moves whole LANE_W-bit lanes of a LANES-lane word by 0..MAX_SHIFT lane positions.
- Modes: shift-left-with-fill, shift-right-with-fill, rotate-left, rotate-right.
- Sits on a valid/ready datapath stream: two register stages, full throughput, backpressure support, saturating error counter.

---
 rtl/lane_shifter_pipe_pkg.sv | 26 ++
 rtl/lane_shifter_pipe_if.sv | 30 +++
 rtl/lane_shifter_pipe_core.sv | 34 +++
 rtl/lane_shifter_pipe.sv | 103 ++++++++++
 tb/tb_lane_shifter_pipe.sv | 382 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lane_shifter_pipe_pkg.sv
// Shared types and helpers for the lane shifter pipeline.
package lane_shift_pkg;

    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        SHL_FILL = 2'b00,
        SHR_FILL = 2'b01,
        ROTL     = 2'b10,
        ROTR     = 2'b11
    } mode_e;

    // Input lane feeding output lane i for a shift of s lanes; -1 selects the fill pattern.
    // Assumes s < lanes, so each wrap needs at most one correction.
    function automatic int lane_src(input int i, input int s, input int lanes, input mode_e mode);
        int src;
        case (mode)
            SHL_FILL: src = (i >= s) ? i - s : -1;
            SHR_FILL: src = (i + s < lanes) ? i + s : -1;
            ROTL:     src = (i >= s) ? i - s : i - s + lanes;
            default:  src = (i + s < lanes) ? i + s : i + s - lanes;
        endcase
        return src;
    endfunction

endpackage

// File: rtl/lane_shifter_pipe_if.sv
// Stream, error and counter signals of the lane shifter pipeline.
interface lane_shifter_pipe_if #(
    parameter int unsigned LANE_W    = 12,
    parameter int unsigned LANES     = 8,
    parameter int unsigned SHIFT_W   = 3,
    parameter int unsigned ERR_CNT_W = 16
);
    logic                              in_valid;
    logic                              in_ready;
    logic [LANES*LANE_W-1:0]           in_data;
    logic [SHIFT_W-1:0]                in_shift;
    logic [lane_shift_pkg::MODE_W-1:0] in_mode;
    logic [LANE_W-1:0]                 in_fill;
    logic                              out_valid;
    logic                              out_ready;
    logic [LANES*LANE_W-1:0]           out_data;
    logic                              out_err;
    logic [ERR_CNT_W-1:0]              err_cnt;
    logic                              err_clr;

    modport master (
        output in_valid, in_data, in_shift, in_mode, in_fill, out_ready, err_clr,
        input  in_ready, out_valid, out_data, out_err, err_cnt
    );

    modport slave (
        input  in_valid, in_data, in_shift, in_mode, in_fill, out_ready, err_clr,
        output in_ready, out_valid, out_data, out_err, err_cnt
    );
endinterface

// File: rtl/lane_shifter_pipe_core.sv
// Combinational lane shifter: moves whole lanes, fills or rotates, flags illegal shifts.
module lane_shift_core
    import lane_shift_pkg::*;
#(
    parameter int unsigned LANE_W    = 12,
    parameter int unsigned LANES     = 8,
    parameter int unsigned SHIFT_W   = 3,
    parameter int unsigned MAX_SHIFT = 5
) (
    input  logic [LANES*LANE_W-1:0] word,
    input  logic [SHIFT_W-1:0]      shift,
    input  mode_e                   mode,
    input  logic [LANE_W-1:0]       fill,
    output logic [LANES*LANE_W-1:0] result,
    output logic                    err
);
    localparam logic [SHIFT_W-1:0] MAX_SHIFT_V = SHIFT_W'(MAX_SHIFT);

    // Per output lane, pick the matching input lane or the fill pattern; zero on illegal shift.
    always_comb begin
        result = '0;
        err    = (shift > MAX_SHIFT_V);
        if (!err) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                result[i*LANE_W +: LANE_W] = fill;
                for (int unsigned j = 0; j < LANES; j++) begin
                    if (lane_src(int'(i), int'(shift), int'(LANES), mode) == int'(j)) begin
                        result[i*LANE_W +: LANE_W] = word[j*LANE_W +: LANE_W];
                    end
                end
            end
        end
    end
endmodule

// File: rtl/lane_shifter_pipe.sv
// Two-stage valid/ready lane shifter with a saturating error-beat counter.
module lane_shifter_pipe
    import lane_shift_pkg::*;
#(
    parameter int unsigned LANE_W    = 12,
    parameter int unsigned LANES     = 8,
    parameter int unsigned SHIFT_W   = 3,
    parameter int unsigned MAX_SHIFT = 5,
    parameter int unsigned ERR_CNT_W = 16
) (
    input logic                clk,
    input logic                rst,
    lane_shifter_pipe_if.slave bus
);
    localparam int unsigned DATA_W = LANES * LANE_W;

    if (!(MAX_SHIFT < LANES && MAX_SHIFT < (1 << SHIFT_W))) begin : g_param_check
        $error("lane_shifter_pipe: MAX_SHIFT must be below LANES and fit in SHIFT_W bits");
    end

    logic                 s1_valid;
    logic [DATA_W-1:0]    s1_data;
    logic [SHIFT_W-1:0]   s1_shift;
    mode_e                s1_mode;
    logic [LANE_W-1:0]    s1_fill;
    logic                 s2_valid;
    logic [DATA_W-1:0]    s2_data;
    logic                 s2_err;
    logic [ERR_CNT_W-1:0] err_cnt;
    logic [DATA_W-1:0]    core_data;
    logic                 core_err;
    logic                 s1_adv;
    logic                 in_ready;
    logic                 accept;
    logic                 s2_load;

    assign s1_adv   = !s2_valid | bus.out_ready;
    assign in_ready = !rst & (!s1_valid | s1_adv);
    assign accept   = bus.in_valid & in_ready;
    assign s2_load  = s1_valid & s1_adv;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.out_err   = s2_err;
    assign bus.err_cnt   = err_cnt;

    lane_shift_core #(
        .LANE_W    (LANE_W),
        .LANES     (LANES),
        .SHIFT_W   (SHIFT_W),
        .MAX_SHIFT (MAX_SHIFT)
    ) u_core (
        .word   (s1_data),
        .shift  (s1_shift),
        .mode   (s1_mode),
        .fill   (s1_fill),
        .result (core_data),
        .err    (core_err)
    );

    // Stage registers: S1 captures accepted beats, S2 holds the result until taken downstream.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_shift <= '0;
            s1_mode  <= SHL_FILL;
            s1_fill  <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_err   <= 1'b0;
        end else begin
            if (accept) begin
                s1_valid <= 1'b1;
                s1_data  <= bus.in_data;
                s1_shift <= bus.in_shift;
                s1_mode  <= mode_e'(bus.in_mode);
                s1_fill  <= bus.in_fill;
            end else if (s1_adv) begin
                s1_valid <= 1'b0;
            end
            if (s1_adv) begin
                s2_valid <= s1_valid;
            end
            if (s2_load) begin
                s2_data <= core_data;
                s2_err  <= core_err;
            end
        end
    end

    // Count error beats as they enter S2; clear wins over increment, count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= '0;
        end else if (bus.err_clr) begin
            err_cnt <= '0;
        end else if (s2_load && core_err && err_cnt != '1) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_lane_shifter_pipe.sv
// Directed and randomised self-checking bench for lane_shifter_pipe.
module tb_lane_shifter_pipe;
    import lane_shift_pkg::*;

    localparam int unsigned LANE_W    = 12;
    localparam int unsigned LANES     = 8;
    localparam int unsigned SHIFT_W   = 3;
    localparam int unsigned MAX_SHIFT = 5;
    localparam int unsigned ERR_CNT_W = 16;
    localparam int unsigned W         = LANES * LANE_W;

    localparam logic [W-1:0] SEQ       = 96'h008_007_006_005_004_003_002_001;
    localparam logic [W-1:0] EXP_SHL2  = 96'h006_005_004_003_002_001_ABC_ABC;
    localparam logic [W-1:0] EXP_SHR2  = 96'hABC_ABC_008_007_006_005_004_003;
    localparam logic [W-1:0] EXP_ROTL3 = 96'h005_004_003_002_001_008_007_006;
    localparam logic [W-1:0] EXP_SHL5  = 96'h003_002_001_ABC_ABC_ABC_ABC_ABC;
    localparam logic [W-1:0] EXP_ROTR1 = 96'h001_008_007_006_005_004_003_002;

    typedef struct {
        logic [W-1:0] d;
        logic         e;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lane_shifter_pipe_if #(
        .LANE_W    (LANE_W),
        .LANES     (LANES),
        .SHIFT_W   (SHIFT_W),
        .ERR_CNT_W (ERR_CNT_W)
    ) bus ();

    lane_shifter_pipe #(
        .LANE_W    (LANE_W),
        .LANES     (LANES),
        .SHIFT_W   (SHIFT_W),
        .MAX_SHIFT (MAX_SHIFT),
        .ERR_CNT_W (ERR_CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference built from whole-word shifts and masks rather than per-lane selection.
    function automatic logic [W-1:0] ref_out(input logic [W-1:0] d, input int unsigned s,
                                             input logic [1:0] m, input logic [LANE_W-1:0] f,
                                             output logic e);
        logic [W-1:0] fw;
        logic [W-1:0] ones;
        logic [W-1:0] r;
        fw   = {LANES{f}};
        ones = '1;
        e    = (s > MAX_SHIFT);
        if (e) return '0;
        case (m)
            2'b00:   r = (d << (s*LANE_W)) | (fw & ~(ones << (s*LANE_W)));
            2'b01:   r = (d >> (s*LANE_W)) | (fw & ~(ones >> (s*LANE_W)));
            2'b10:   r = (d << (s*LANE_W)) | (d >> ((LANES-s)*LANE_W));
            default: r = (d >> (s*LANE_W)) | (d << ((LANES-s)*LANE_W));
        endcase
        return r;
    endfunction

    function automatic logic [W-1:0] gen_word(input int k);
        logic [W-1:0] d;
        for (int j = 0; j < int'(LANES); j++) d[j*LANE_W +: LANE_W] = 12'(k*16 + j + 1);
        return d;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_shift = '0;
        bus.in_mode  = '0;
        bus.in_fill  = '0;
    endtask

    task automatic drive_beat(input logic [W-1:0] d, input int unsigned s, input logic [1:0] m,
                              input logic [LANE_W-1:0] f);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shift = SHIFT_W'(s);
        bus.in_mode  = m;
        bus.in_fill  = f;
    endtask

    // One beat through an empty pipe: v1/v2 are out_valid one and two cycles after presentation.
    task automatic pipe_single(input logic [W-1:0] d, input int unsigned s, input logic [1:0] m,
                               input logic [LANE_W-1:0] f, output logic v1, output logic v2,
                               output logic [W-1:0] od, output logic oe);
        bus.out_ready = 1'b1;
        drive_beat(d, s, m, f);
        next_cycle();
        bus.in_valid = 1'b0;
        @(negedge clk);
        v1 = bus.out_valid;
        next_cycle();
        @(negedge clk);
        v2 = bus.out_valid;
        od = bus.out_data;
        oe = bus.out_err;
        next_cycle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.out_ready = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready_low: got %b expected 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready_after: got %b expected 1", bus.in_ready); end
        checks++; if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h expected 0", bus.out_data); end
        checks++; if (bus.out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b expected 0", bus.out_err); end
        checks++; if (bus.err_cnt !== '0) begin errors++; $display("FAIL reset_err_cnt: got %h expected 0", bus.err_cnt); end
        next_cycle();
    endtask

    task automatic test_shl();
        logic v1, v2, oe;
        logic [W-1:0] od;
        pipe_single(SEQ, 2, SHL_FILL, 12'hABC, v1, v2, od, oe);
        checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL shl_latency_early: got %b expected 0", v1); end
        checks++; if (v2 !== 1'b1) begin errors++; $display("FAIL shl_latency_valid: got %b expected 1", v2); end
        checks++; if (od !== EXP_SHL2) begin errors++; $display("FAIL shl2_data: got %h expected %h", od, EXP_SHL2); end
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL shl2_err: got %b expected 0", oe); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL shl_no_duplicate: got %b expected 0", bus.out_valid); end
        next_cycle();
    endtask

    task automatic test_shr_rotl();
        logic v1, v2, oe;
        logic [W-1:0] od;
        pipe_single(SEQ, 2, SHR_FILL, 12'hABC, v1, v2, od, oe);
        checks++; if (od !== EXP_SHR2 || v2 !== 1'b1) begin errors++; $display("FAIL shr2_data: got %h/%b expected %h/1", od, v2, EXP_SHR2); end
        pipe_single(SEQ, 3, ROTL, 12'hABC, v1, v2, od, oe);
        checks++; if (od !== EXP_ROTL3 || oe !== 1'b0) begin errors++; $display("FAIL rotl3_data: got %h/%b expected %h/0", od, oe, EXP_ROTL3); end
    endtask

    task automatic test_boundaries();
        logic v1, v2, oe;
        logic [W-1:0] od;
        pipe_single(SEQ, 5, SHL_FILL, 12'hABC, v1, v2, od, oe);
        checks++; if (od !== EXP_SHL5 || oe !== 1'b0) begin errors++; $display("FAIL shl_max_shift: got %h/%b expected %h/0", od, oe, EXP_SHL5); end
        pipe_single(SEQ, 0, ROTR, 12'hABC, v1, v2, od, oe);
        checks++; if (od !== SEQ) begin errors++; $display("FAIL rotr_zero_shift: got %h expected %h", od, SEQ); end
        pipe_single(SEQ, 0, SHR_FILL, 12'hABC, v1, v2, od, oe);
        checks++; if (od !== SEQ) begin errors++; $display("FAIL shr_zero_shift: got %h expected %h", od, SEQ); end
        pipe_single(SEQ, 1, ROTR, 12'hABC, v1, v2, od, oe);
        checks++; if (od !== EXP_ROTR1) begin errors++; $display("FAIL rotr1_data: got %h expected %h", od, EXP_ROTR1); end
    endtask

    task automatic test_errors();
        logic v1, v2, oe;
        logic [W-1:0] od;
        pipe_single(SEQ, 6, SHL_FILL, 12'hABC, v1, v2, od, oe);
        checks++; if (od !== '0 || oe !== 1'b1 || v2 !== 1'b1) begin errors++; $display("FAIL err_shl6: got %h/%b/%b expected 0/1/1", od, oe, v2); end
        pipe_single(SEQ, 7, ROTR, 12'hABC, v1, v2, od, oe);
        checks++; if (od !== '0 || oe !== 1'b1) begin errors++; $display("FAIL err_rotr7: got %h/%b expected 0/1", od, oe); end
        checks++; if (bus.err_cnt !== 16'd2) begin errors++; $display("FAIL err_cnt_two: got %h expected 0002", bus.err_cnt); end
        // Clear in the same cycle an error beat enters S2.
        drive_beat(SEQ, 7, ROTL, 12'h000);
        next_cycle();
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b1;
        next_cycle();
        bus.err_clr = 1'b0;
        @(negedge clk);
        checks++; if (bus.err_cnt !== '0) begin errors++; $display("FAIL err_clr_priority: got %h expected 0000", bus.err_cnt); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_err !== 1'b1) begin errors++; $display("FAIL err_clr_beat_emitted: got %b/%b expected 1/1", bus.out_valid, bus.out_err); end
        next_cycle();
        pipe_single(SEQ, 7, SHR_FILL, 12'h000, v1, v2, od, oe);
        checks++; if (bus.err_cnt !== 16'd1) begin errors++; $display("FAIL err_cnt_one: got %h expected 0001", bus.err_cnt); end
        bus.err_clr = 1'b1;
        next_cycle();
        bus.err_clr = 1'b0;
        checks++; if (bus.err_cnt !== '0) begin errors++; $display("FAIL err_clr_alone: got %h expected 0000", bus.err_cnt); end
        // Pump the counter to all-ones with back-to-back error beats.
        drive_beat(SEQ, 7, ROTL, 12'h000);
        repeat (65535) next_cycle();
        bus.in_valid = 1'b0;
        next_cycle();
        next_cycle();
        checks++; if (bus.err_cnt !== 16'hFFFF) begin errors++; $display("FAIL err_cnt_full: got %h expected ffff", bus.err_cnt); end
        pipe_single(SEQ, 6, SHR_FILL, 12'h000, v1, v2, od, oe);
        checks++; if (bus.err_cnt !== 16'hFFFF || oe !== 1'b1) begin errors++; $display("FAIL err_cnt_saturate: got %h/%b expected ffff/1", bus.err_cnt, oe); end
        bus.err_clr = 1'b1;
        next_cycle();
        bus.err_clr = 1'b0;
        checks++; if (bus.err_cnt !== '0) begin errors++; $display("FAIL err_clr_from_full: got %h expected 0000", bus.err_cnt); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] exp_d [10];
        logic         exp_e [10];
        for (int k = 0; k < 10; k++) exp_d[k] = ref_out(gen_word(k), k % 6, 2'(k % 4), 12'(12'hF00 + k), exp_e[k]);
        bus.out_ready = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (cyc < 10) drive_beat(gen_word(cyc), cyc % 6, 2'(cyc % 4), 12'(12'hF00 + cyc));
            else bus.in_valid = 1'b0;
            @(negedge clk);
            if (cyc < 10) begin
                checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready cyc %0d: got %b expected 1", cyc, bus.in_ready); end
            end
            if (cyc >= 2 && cyc < 12) begin
                checks++;
                if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d[cyc-2] || bus.out_err !== exp_e[cyc-2]) begin
                    errors++;
                    $display("FAIL b2b_beat %0d: got %b/%h/%b expected 1/%h/%b", cyc-2, bus.out_valid, bus.out_data, bus.out_err, exp_d[cyc-2], exp_e[cyc-2]);
                end
            end else begin
                checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle cyc %0d: got %b expected 0", cyc, bus.out_valid); end
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] exp_d [10];
        logic         exp_e [10];
        logic [W-1:0] held;
        int sent = 0;
        int recv = 0;
        int cyc  = 0;
        for (int k = 0; k < 10; k++) exp_d[k] = ref_out(gen_word(k + 20), (k + 1) % 6, 2'(k % 4), 12'(12'hE00 + k), exp_e[k]);
        held = '0;
        while (recv < 10 && cyc < 60) begin
            bus.out_ready = !(cyc >= 4 && cyc < 9);
            if (sent < 10) drive_beat(gen_word(sent + 20), (sent + 1) % 6, 2'(sent % 4), 12'(12'hE00 + sent));
            else bus.in_valid = 1'b0;
            @(negedge clk);
            if (cyc >= 4 && cyc < 9) begin
                checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready cyc %0d: got %b expected 0", cyc, bus.in_ready); end
            end
            if (cyc == 4) held = bus.out_data;
            if (cyc > 4 && cyc < 9) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== held) begin errors++; $display("FAIL stall_hold cyc %0d: got %b/%h expected 1/%h", cyc, bus.out_valid, bus.out_data, held); end
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (bus.out_data !== exp_d[recv] || bus.out_err !== exp_e[recv]) begin
                    errors++;
                    $display("FAIL stall_beat %0d: got %h/%b expected %h/%b", recv, bus.out_data, bus.out_err, exp_d[recv], exp_e[recv]);
                end
                recv++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
            next_cycle();
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++; if (recv != 10) begin errors++; $display("FAIL stall_count: got %0d expected 10", recv); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL stall_no_extra: got %b expected 0", bus.out_valid); end
        next_cycle();
    endtask

    task automatic test_reset_midflight();
        logic v1, v2, oe;
        logic [W-1:0] od;
        int seen;
        bus.out_ready = 1'b0;
        drive_beat(SEQ, 7, SHL_FILL, 12'h111);
        next_cycle();
        drive_beat(SEQ, 6, ROTL, 12'h222);
        next_cycle();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.err_cnt !== 16'd1) begin errors++; $display("FAIL midflight_pre: got %b/%h expected 1/0001", bus.out_valid, bus.err_cnt); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL midflight_in_ready_rst: got %b expected 0", bus.in_ready); end
        next_cycle();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0 || bus.err_cnt !== '0) begin errors++; $display("FAIL midflight_post: got %b/%h expected 0/0000", bus.out_valid, bus.err_cnt); end
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midflight_ghost: got %0d beats expected 0", seen); end
        next_cycle();
        pipe_single(SEQ, 1, ROTR, 12'h000, v1, v2, od, oe);
        checks++; if (v1 !== 1'b0 || v2 !== 1'b1 || od !== EXP_ROTR1) begin errors++; $display("FAIL midflight_new_beat: got %b/%b/%h expected 0/1/%h", v1, v2, od, EXP_ROTR1); end
    endtask

    task automatic test_random();
        localparam int N = 6000;
        exp_t q[$];
        exp_t ex;
        exp_t got;
        logic [W-1:0] d;
        int unsigned s;
        logic [1:0] m;
        logic [LANE_W-1:0] f;
        int sent = 0;
        int recv = 0;
        int errbeats = 0;
        int cyc = 0;
        logic acc = 1'b0;
        bus.err_clr = 1'b1;
        next_cycle();
        bus.err_clr = 1'b0;
        while (recv < N && cyc < 40000) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid || acc) begin
                if (sent < N && $urandom_range(0, 3) != 0) begin
                    d = {$urandom(), $urandom(), $urandom()};
                    s = $urandom_range(0, 7);
                    m = 2'($urandom_range(0, 3));
                    f = 12'($urandom());
                    drive_beat(d, s, m, f);
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            if (acc) begin
                ex.d = ref_out(bus.in_data, int'(bus.in_shift), bus.in_mode, bus.in_fill, ex.e);
                if (ex.e) errbeats++;
                q.push_back(ex);
                sent++;
            end
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL rand_unexpected_beat: got %h expected none", bus.out_data);
                end else begin
                    got = q.pop_front();
                    if (bus.out_data !== got.d || bus.out_err !== got.e) begin
                        errors++;
                        $display("FAIL rand_beat %0d: got %h/%b expected %h/%b", recv, bus.out_data, bus.out_err, got.d, got.e);
                    end
                end
                recv++;
            end
            next_cycle();
            cyc++;
        end
        bus.in_valid = 1'b0;
        checks++; if (recv != N) begin errors++; $display("FAIL rand_count: got %0d expected %0d", recv, N); end
        checks++; if (bus.err_cnt !== ERR_CNT_W'(errbeats)) begin errors++; $display("FAIL rand_err_cnt: got %0d expected %0d", bus.err_cnt, errbeats); end
    endtask

    initial begin
        rst = 1'b1;
        bus.out_ready = 1'b0;
        bus.err_clr   = 1'b0;
        idle_inputs();
        test_reset();
        test_shl();
        test_shr_rotl();
        test_boundaries();
        test_errors();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
